uart_apb_slave: RTL and testbench

//  APB register slave for the UART block: baud divisor, control, status, TX and RX data registers.

---
 rtl/uart_apb_slave.sv | 103 ++++++++++
 tb/tb_uart_apb_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_slave.sv
// rtl/uart_apb_slave.sv - APB register slave for the UART: baud, control, status, TX and RX data.
module uart_apb_slave #(
  parameter logic [7:0] BAUD_RST = 8'h00,
  parameter logic [7:0] CTRL_RST = 8'h00
) (
  input  logic        P_clk,
  input  logic        P_resetn,
  input  logic        P_sel,
  input  logic        P_enable,
  input  logic        P_write,
  input  logic [31:0] P_address,
  input  logic [7:0]  PW_data,
  output logic [7:0]  PR_data,
  output logic        P_ready,
  output logic [7:0]  baud_div,
  output logic [7:0]  ctrl,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_byte,
  input  logic        rx_par_err
);

  localparam logic [31:0] ADDR_BAUD   = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0008;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_000C;
  localparam logic [31:0] ADDR_RXDATA = 32'h0000_0010;

  logic [7:0] baud_q;
  logic [4:0] ctrl_q;
  logic [7:0] rx_buf;
  logic       rx_valid;
  logic       rx_overrun;
  logic       par_err;

  logic sel_baud, sel_ctrl, sel_status, sel_tx, sel_rx;
  logic access, wr_en, rd_en;
  logic rx_evt, rx_rd, w1c, tx_fire;
  logic [7:0] status;

  assign sel_baud   = (P_address == ADDR_BAUD);
  assign sel_ctrl   = (P_address == ADDR_CTRL);
  assign sel_status = (P_address == ADDR_STATUS);
  assign sel_tx     = (P_address == ADDR_TXDATA);
  assign sel_rx     = (P_address == ADDR_RXDATA);

  assign access  = P_sel & P_enable;
  assign wr_en   = access & P_write;
  assign rd_en   = access & ~P_write;
  assign P_ready = access;

  assign rx_evt  = rx_strobe & ctrl_q[1];
  assign rx_rd   = rd_en & sel_rx;
  assign w1c     = wr_en & sel_status;
  assign tx_fire = wr_en & sel_tx & ctrl_q[0] & ~tx_busy;

  assign status   = {4'b0000, par_err, rx_overrun, rx_valid, tx_busy};
  assign baud_div = baud_q;
  assign ctrl     = {3'b000, ctrl_q};

  always_comb begin
    PR_data = 8'h00;
    if (P_sel && !P_write) begin
      if (sel_baud)        PR_data = baud_q;
      else if (sel_ctrl)   PR_data = ctrl;
      else if (sel_status) PR_data = status;
      else if (sel_rx)     PR_data = rx_buf;
    end
  end

  always_ff @(posedge P_clk or negedge P_resetn) begin
    if (!P_resetn) begin
      baud_q     <= BAUD_RST;
      ctrl_q     <= CTRL_RST[4:0];
      rx_buf     <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      par_err    <= 1'b0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
    end else begin
      tx_start <= tx_fire;
      if (tx_fire)           tx_data <= PW_data;
      if (wr_en && sel_baud) baud_q  <= PW_data;
      if (wr_en && sel_ctrl) ctrl_q  <= PW_data[4:0];
      if (rx_evt)            rx_buf  <= rx_byte;

      // A byte arriving on the same cycle as the RXDATA read replaces the one being read,
      // so it stays valid and is not counted as an overrun.
      if (rx_evt)     rx_valid <= 1'b1;
      else if (rx_rd) rx_valid <= 1'b0;

      if (rx_evt && rx_valid && !rx_rd) rx_overrun <= 1'b1;
      else if (w1c && PW_data[2])       rx_overrun <= 1'b0;

      if (rx_evt && rx_par_err)   par_err <= 1'b1;
      else if (w1c && PW_data[3]) par_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_apb_slave.sv
// tb/tb_uart_apb_slave.sv - scoreboard bench for uart_apb_slave against a register-level model.
module tb_uart_apb_slave;

  logic        P_clk = 1'b0;
  logic        P_resetn = 1'b0;
  logic        P_sel = 1'b0;
  logic        P_enable = 1'b0;
  logic        P_write = 1'b0;
  logic [31:0] P_address = 32'h0;
  logic [7:0]  PW_data = 8'h00;
  logic [7:0]  PR_data;
  logic        P_ready;
  logic [7:0]  baud_div;
  logic [7:0]  ctrl;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_strobe = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_par_err = 1'b0;

  uart_apb_slave dut (
    .P_clk(P_clk), .P_resetn(P_resetn), .P_sel(P_sel), .P_enable(P_enable),
    .P_write(P_write), .P_address(P_address), .PW_data(PW_data), .PR_data(PR_data),
    .P_ready(P_ready), .baud_div(baud_div), .ctrl(ctrl), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .rx_strobe(rx_strobe), .rx_byte(rx_byte),
    .rx_par_err(rx_par_err)
  );

  always #5 P_clk = ~P_clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];

  logic [7:0] m_baud, m_ctrl, m_rxbuf, m_txdata;
  bit         m_valid, m_ovr, m_perr;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_baud = 8'h00; m_ctrl = 8'h00; m_rxbuf = 8'h00; m_txdata = 8'h00;
    m_valid = 0; m_ovr = 0; m_perr = 0;
  endfunction

  function automatic logic [7:0] model_read(logic [31:0] a);
    case (a)
      32'h00:  return m_baud;
      32'h04:  return m_ctrl;
      32'h08:  return {4'b0, m_perr, m_ovr, m_valid, tx_busy};
      32'h10:  return m_rxbuf;
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the register map: all decisions use the state from before the edge.
  function automatic void model_step(bit wr, bit rd, logic [31:0] a, logic [7:0] d,
                                     bit rx, logic [7:0] rb, bit pe);
    bit rx_ev, rd_rx, old_valid;
    logic [7:0] old_ctrl;
    old_ctrl  = m_ctrl;
    old_valid = m_valid;
    rx_ev = rx && old_ctrl[1];
    rd_rx = rd && (a == 32'h10);
    if (wr) begin
      if (a == 32'h00) m_baud = d;
      if (a == 32'h04) m_ctrl = d & 8'h1F;
      if (a == 32'h08 && d[2]) m_ovr = 0;
      if (a == 32'h08 && d[3]) m_perr = 0;
      if (a == 32'h0C && old_ctrl[0] && !tx_busy) begin
        m_txdata = d;
        tx_q.push_back(d);
      end
    end
    if (rx_ev) begin
      m_rxbuf = rb;
      if (old_valid && !rd_rx) m_ovr = 1;
      if (pe) m_perr = 1;
      m_valid = 1;
    end else if (rd_rx) begin
      m_valid = 0;
    end
  endfunction

  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [7:0] d,
                          input bit rx, input logic [7:0] rb, input bit pe);
    if (!wr) rd_q.push_back(model_read(a));
    @(posedge P_clk); #1;
    P_sel = 1; P_enable = 0; P_write = wr; P_address = a; PW_data = d;
    @(posedge P_clk); #1;
    P_enable = 1; rx_strobe = rx; rx_byte = rb; rx_par_err = pe;
    @(posedge P_clk);
    model_step(wr, !wr, a, d, rx, rb, pe);
    #1;
    P_sel = 0; P_enable = 0; P_write = 0; rx_strobe = 0; rx_par_err = 0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [7:0] d);
    apb_xfer(1, a, d, 0, 8'h00, 0);
  endtask

  task automatic apb_rd(input logic [31:0] a);
    apb_xfer(0, a, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic rx_only(input logic [7:0] rb, input bit pe);
    @(posedge P_clk); #1;
    rx_strobe = 1; rx_byte = rb; rx_par_err = pe;
    @(posedge P_clk);
    model_step(0, 0, 32'h0, 8'h00, 1, rb, pe);
    #1;
    rx_strobe = 0; rx_par_err = 0;
  endtask

  bit mon_en = 0;

  always @(negedge P_clk) begin
    if (mon_en) begin
      chk("p_ready", {7'b0, P_ready}, {7'b0, P_sel & P_enable});
      chk("baud_div", baud_div, m_baud);
      chk("ctrl_out", ctrl, m_ctrl);
      if (P_sel && P_enable && !P_write) begin
        if (rd_q.size() == 0) chk("unexpected_read", PR_data, 8'hxx);
        else chk("read_data", PR_data, rd_q.pop_front());
      end
      if (tx_start) begin
        if (tx_q.size() == 0) chk("unexpected_tx_start", 8'h01, 8'h00);
        else chk("tx_data_on_start", tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] addrs [0:6];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h8000_0000};
    model_reset();
    repeat (3) @(posedge P_clk);
    #1;
    chk("rst_baud", baud_div, 8'h00);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_tx_start", {7'b0, tx_start}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    P_resetn = 1;
    mon_en = 1;
    for (int i = 0; i < 5; i++) apb_rd(addrs[i]);

    apb_wr(32'h00, 8'h12);
    apb_rd(32'h00);
    chk("baud_12", baud_div, 8'h12);

    apb_wr(32'h04, 8'h03);
    apb_wr(32'h0C, 8'hA5);
    chk("tx_data_a5", tx_data, 8'hA5);
    tx_busy = 1;
    apb_wr(32'h0C, 8'h5A);
    chk("tx_data_held", tx_data, 8'hA5);
    apb_rd(32'h08);
    tx_busy = 0;

    rx_only(8'h3C, 0);
    rx_only(8'h7E, 0);
    apb_rd(32'h08);
    apb_rd(32'h10);
    apb_rd(32'h08);
    apb_wr(32'h08, 8'h04);
    apb_rd(32'h08);
    chk("status_clear_model", {m_perr, m_ovr, m_valid}, 8'h00);

    rx_only(8'h11, 0);
    apb_xfer(0, 32'h10, 8'h00, 1, 8'h22, 0);
    apb_rd(32'h08);
    apb_rd(32'h10);

    apb_wr(32'h20, 8'hFF);
    apb_wr(32'h8000_0000, 8'hFF);
    apb_rd(32'h20);
    apb_rd(32'h8000_0000);
    apb_rd(32'h00);
    apb_rd(32'h04);

    rx_only(8'h01, 1);
    apb_rd(32'h08);
    apb_xfer(1, 32'h08, 8'h0C, 1, 8'h02, 1);
    apb_rd(32'h08);
    apb_wr(32'h08, 8'h0C);
    apb_wr(32'h04, 8'h01);
    rx_only(8'h99, 1);
    apb_rd(32'h08);
    apb_rd(32'h10);

    @(posedge P_clk); #1;
    P_sel = 1; P_enable = 0; P_write = 1; P_address = 32'h00; PW_data = 8'hEE;
    @(posedge P_clk); #1;
    P_enable = 1;
    #2;
    P_resetn = 0;
    model_reset();
    #1;
    chk("mid_rst_baud", baud_div, 8'h00);
    chk("mid_rst_ctrl", ctrl, 8'h00);
    chk("mid_rst_tx_start", {7'b0, tx_start}, 8'h00);
    @(posedge P_clk); #1;
    P_sel = 0; P_enable = 0; P_write = 0;
    repeat (2) @(posedge P_clk);
    #1;
    P_resetn = 1;
    apb_rd(32'h00);
    apb_rd(32'h04);
    apb_rd(32'h08);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int op;
      a = ($urandom_range(0, 9) == 0) ? $urandom() : addrs[$urandom_range(0, 6)];
      tx_busy = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 4);
      case (op)
        0: apb_wr(a, 8'($urandom()));
        1: apb_rd(a);
        2: rx_only(8'($urandom()), $urandom_range(0, 1) == 1);
        3: apb_xfer(0, 32'h10, 8'h00, 1, 8'($urandom()), $urandom_range(0, 1) == 1);
        default: apb_xfer(1, a, 8'($urandom()), $urandom_range(0, 1) == 1,
                          8'($urandom()), $urandom_range(0, 1) == 1);
      endcase
    end

    repeat (3) @(posedge P_clk);
    #1;
    chk("tx_data_final", tx_data, m_txdata);
    chk("pending_reads", 8'(rd_q.size()), 8'h00);
    chk("pending_tx", 8'(tx_q.size()), 8'h00);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
